airi5c_lzc_norm_seq: RTL
========================

Name: airi5c_lzc_norm_seq

Overview:
Multi-cycle normalizer for 64-bit mantissas. It shares one instance of the existing 32-bit leading-zero counter (airi5c_leading_zero_counter_32: in[31:0] -> y[4:0], a = all-zero) across the upper and lower words. It then left-shifts the operand by the count, clamped to a caller-supplied limit so that denormal results can be produced. It sits between the FPU mul/div/fma mantissa datapaths and the rounding stage, with valid/ready handshakes on both sides.

Parameters:
FAST_ZERO_SHIFT, 1, when 1 a final shift amount of 0 skips the SHIFT state, saving one cycle of latency; when 0 the latency is fixed per path.

Ports:
clk  input  1  clock, all state on rising edge
n_reset  input  1  asynchronous active-low reset
kill  input  1  synchronous abort of the current operation (pipeline flush)
in_valid  input  1  operand valid
in_ready  output  1  operand accepted when in_valid && in_ready
in_data  input  64  unnormalized mantissa
in_max_shift  input  7  maximum allowed left shift (0..127)
out_valid  output  1  result valid, held until out_ready
out_ready  input  1  consumer ready
out_data  output  64  normalized mantissa
out_shamt  output  7  applied shift amount
out_zero  output  1  operand was all-zero
out_sat  output  1  leading-zero count exceeded in_max_shift, so the shift was clamped
busy  output  1  state != IDLE

Behaviour:
- Reset (n_reset low, asynchronous): state = IDLE; out_valid, out_data, out_shamt, out_zero, out_sat and busy all 0; internal operand, count and limit registers all 0.
- States: IDLE, HI, LO, SHIFT, DONE.
- in_ready = !kill && (state==IDLE || (state==DONE && out_ready)).
- On acceptance, in_data and in_max_shift are registered and the next state is HI.
- LZC input mux: upper word in HI, lower word otherwise. Only one LZC instance is allowed.
- HI state:
  - if the upper word is non-zero: lz = y; go to SHIFT.
  - else go to LO.
- LO state:
  - if the lower word is non-zero: lz = 32 + y; go to SHIFT.
  - else (operand zero): go to DONE with out_data = 0, out_shamt = 64, out_zero = 1, out_sat = 0. No clamping applies.
- Clamp: shamt = min(lz, max_shift); out_sat = (lz > max_shift). It is computed and registered on the HI/LO exit edge.
- SHIFT state: out_data <= operand << shamt (7-bit shamt, zero-fill, bits shifted past bit 63 discarded); then go to DONE.
- FAST_ZERO_SHIFT = 1 and shamt == 0: HI/LO goes directly to DONE with out_data = operand.
- DONE state: out_valid = 1; all out_* hold stable until out_ready.
  - out_ready with new in_valid: accept, go to HI (back-to-back, no idle bubble).
  - out_ready without new in_valid: go to IDLE.
- Latency from the acceptance edge t to out_valid high:
  - upper-word path: t+3
  - lower-word path: t+4
  - zero operand: t+3
  - fast zero-shift path: t+2 (upper word) / t+3 (lower word)
- kill: highest priority in every state. Next state = IDLE, out_valid = 0 next cycle, out_* data registers cleared to 0. A result in DONE is discarded even if out_ready is high in the same cycle. No acceptance occurs in a kill cycle.
- Reset mid-operation: immediate return to the reset values; no partial result is ever emitted.
- Unused lz values: the LZC 'a' output selects the path; the y value is ignored when a = 1.

Test Plan:
1. in_data = 0x0001_0000_0000_0000, max_shift = 127, out_ready = 1 -> out_valid at t+3; out_data = 0x8000_0000_0000_0000, out_shamt = 15, out_sat = 0, out_zero = 0.
2. in_data = 0x0000_0000_0000_0001, max_shift = 127 -> out_valid at t+4; out_data = 0x8000_0000_0000_0000, out_shamt = 63.
3. in_data = 0 -> out_valid at t+3; out_data = 0, out_shamt = 64, out_zero = 1, out_sat = 0.
4. in_data = 0x0000_0000_0000_00FF, max_shift = 10 -> out_shamt = 10, out_data = 0x0000_0000_0003_FC00, out_sat = 1. Then in_data = 0x8000_0000_0000_0000 with FAST_ZERO_SHIFT = 1 -> out_valid at t+2, out_shamt = 0.
5. Backpressure: hold out_ready low for 5 cycles in DONE -> out_* stable and in_ready = 0. Then raise out_ready with in_valid high -> new operand accepted in the same cycle and state = HI next cycle.
6. kill asserted while in LO (and separately n_reset pulsed in SHIFT) -> next cycle IDLE, busy = 0, out_valid never asserted, out_data = 0; a following operand completes normally.

Source files
------------

// File: rtl/airi5c_lzc_norm_seq.sv
// Multi-cycle 64-bit mantissa normalizer. One shared 32-bit leading-zero counter scans the upper
// then the lower word, and the left shift is clamped to a caller limit so denormals can be formed.

module airi5c_leading_zero_counter_32 (
  input  logic [31:0] in,
  output logic [4:0]  y,
  output logic        a
);
  always_comb begin
    y = 5'd0;
    // The highest set bit is visited last, so it decides the count.
    for (int i = 0; i < 32; i++) begin
      if (in[i]) y = 5'(31 - i);
    end
  end

  assign a = ~|in;
endmodule

// state | meaning
// IDLE  | waiting for an operand
// HI    | counting leading zeros of the upper word
// LO    | upper word was zero, counting the lower word
// SHIFT | applying the clamped left shift
// DONE  | result presented, waiting for out_ready
module airi5c_lzc_norm_seq #(
  parameter bit FAST_ZERO_SHIFT = 1'b1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        kill,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [6:0]  in_max_shift,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [6:0]  out_shamt,
  output logic        out_zero,
  output logic        out_sat,
  output logic        busy
);
  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_SHIFT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] op_q, op_d;
  logic [6:0]  lim_q, lim_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  logic [6:0]  out_shamt_q, out_shamt_d;
  logic        out_zero_q, out_zero_d;
  logic        out_sat_q, out_sat_d;

  logic [31:0] lzc_in;
  logic [4:0]  lzc_y;
  logic        lzc_a;
  logic [6:0]  lz;
  logic [6:0]  clamp_shamt;
  logic        clamp_sat;

  assign lzc_in = (state_q == S_HI) ? op_q[63:32] : op_q[31:0];

  airi5c_leading_zero_counter_32 u_lzc (
    .in (lzc_in),
    .y  (lzc_y),
    .a  (lzc_a)
  );

  assign lz          = (state_q == S_HI) ? {2'b00, lzc_y} : 7'd32 + {2'b00, lzc_y};
  assign clamp_sat   = lz > lim_q;
  assign clamp_shamt = clamp_sat ? lim_q : lz;

  assign in_ready = !kill && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lim_d       = lim_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_shamt_d = out_shamt_q;
    out_zero_d  = out_zero_q;
    out_sat_d   = out_sat_q;

    if (kill) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      out_data_d  = 64'd0;
      out_shamt_d = 7'd0;
      out_zero_d  = 1'b0;
      out_sat_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d    = in_data;
            lim_d   = in_max_shift;
            state_d = S_HI;
          end
        end
        S_HI, S_LO: begin
          if (!lzc_a) begin
            cnt_d       = clamp_shamt;
            out_shamt_d = clamp_shamt;
            out_sat_d   = clamp_sat;
            out_zero_d  = 1'b0;
            if (FAST_ZERO_SHIFT && (clamp_shamt == 7'd0)) begin
              out_data_d  = op_q;
              out_valid_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              state_d = S_SHIFT;
            end
          end else if (state_q == S_HI) begin
            state_d = S_LO;
          end else begin
            // Zero operand reports the full width and is never flagged as clamped.
            out_data_d  = 64'd0;
            out_shamt_d = 7'd64;
            out_zero_d  = 1'b1;
            out_sat_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
        S_SHIFT: begin
          out_data_d  = op_q << cnt_q;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (in_valid) begin
              op_d    = in_data;
              lim_d   = in_max_shift;
              state_d = S_HI;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      op_q        <= 64'd0;
      lim_q       <= 7'd0;
      cnt_q       <= 7'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
      out_shamt_q <= 7'd0;
      out_zero_q  <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lim_q       <= lim_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_shamt_q <= out_shamt_d;
      out_zero_q  <= out_zero_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_shamt = out_shamt_q;
  assign out_zero  = out_zero_q;
  assign out_sat   = out_sat_q;
  assign busy      = (state_q != S_IDLE);
endmodule
